// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder bit per clock, LSB first,
// with valid/ready handshakes on both the operand and the result side.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] result;
    logic             cout_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic [IW-1:0]    idx;
    logic             abit;
    logic             bbit;
    logic             sum_bit;
    logic             carry_nxt;
    logic             last;

    assign idx       = cnt[IW-1:0];
    assign abit      = a_reg[idx];
    assign bbit      = b_reg[idx];
    assign sum_bit   = abit ^ bbit ^ carry;
    assign carry_nxt = (abit & bbit) | (abit & carry) | (bbit & carry);
    assign last      = (cnt == CW'(WIDTH - 1));

    // NOTE: operand registers are only read while in RUN after a load, so
    // they carry no reset; this keeps them out of the async-reset flop group.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_reg <= A;
            b_reg <= B ^ {WIDTH{Sub}};
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // sees pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            cout_reg  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1, with the borrow-in folded into the carry.
                        carry    <= Cin ^ Sub;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    result <= {sum_bit, result[WIDTH-1:1]};
                    carry  <= carry_nxt;
                    if (last) begin
                        cout_reg  <= carry_nxt;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign Sum  = result;
    assign Cout = cout_reg;

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand set on A/B/Cin/Sub is valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 A  input  WIDTH  first operand, unsigned.
REQ-007 B  input  WIDTH  second operand, unsigned.
REQ-008 Cin  input  1  carry-in for add; borrow-in for subtract.
REQ-009 Sub  input  1  0 = add, 1 = subtract.
REQ-010 out_valid  output  1  Sum/Cout hold a completed result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 Sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 Cout  output  1  add: carry-out; subtract: 1 = no borrow (A >= B+Cin).
REQ-014 busy  output  1  high while in RUN.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-016 IDLE: in_ready=1, out_valid=0, busy=0; in_valid=1 at a rising edge -> accept, go to RUN.
REQ-017 On accept, the block SHALL register A, B^{WIDTH{Sub}} and carry = Cin^Sub, and clear the bit counter to 0.
REQ-018 RUN: in_ready=0, busy=1; each cycle one full-adder bit SHALL be computed from operand bit[cnt], second bit[cnt] and carry, with carry updated.
REQ-019 RUN: each sum bit SHALL be shifted into the result register LSB-first so that after WIDTH bits, Sum[i] equals result bit i.
REQ-020 RUN SHALL last exactly WIDTH cycles; on the edge processing bit WIDTH-1 the FSM SHALL go to DONE and capture the final carry as Cout.
REQ-021 Latency: accept at edge k -> out_valid=1 after edge k+WIDTH.
REQ-022 Add: {Cout,Sum} SHALL equal A+B+Cin.
REQ-023 Subtract: Sum SHALL equal (A-B-Cin) mod 2^WIDTH; Cout SHALL be 1 iff A >= B+Cin.
REQ-024 DONE: out_valid=1, in_ready=0, busy=0; Sum/Cout SHALL hold stable until out_valid && out_ready at a rising edge, then the FSM goes to IDLE.
REQ-025 in_valid and operand changes during RUN or DONE SHALL be ignored and SHALL not alter the result in progress.
REQ-026 A new operand set SHALL NOT be accepted in the same cycle as the result handshake; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-027 Sum/Cout outside DONE are don't-care to consumers but SHALL NOT change in IDLE after a completed handshake, i.e. they keep the last result.
REQ-028 The bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within RUN.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock, force state=IDLE, counter=0, carry=0, result register=0, Cout=0.
REQ-030 Reset outputs: in_ready=1, out_valid=0, busy=0, Sum=0, Cout=0.
REQ-031 Reset asserted mid-RUN or in DONE SHALL abort the operation; no out_valid SHALL follow the deassertion without a new accept.
REQ-032 The first accept SHALL be possible on the first rising edge after rst_n deassertion.

Verification (WIDTH=8)
REQ-033 Add A=0x0F,B=0x01,Cin=0 -> out_valid on edge 8 after accept, Sum=0x10, Cout=0; busy high for exactly 8 cycles.
REQ-034 Add A=0xFF,B=0x01,Cin=1 -> Sum=0x01, Cout=1; Add A=0xFF,B=0xFF,Cin=1 -> Sum=0xFF, Cout=1.
REQ-035 Sub A=0x05,B=0x07,Cin=0 -> Sum=0xFE, Cout=0; Sub A=0x10,B=0x10,Cin=0 -> Sum=0x00, Cout=1; Sub A=0x10,B=0x0F,Cin=1 -> Sum=0x00, Cout=1.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, Sum/Cout unchanged, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-037 Disturbance: toggle in_valid and randomize A/B/Sub every cycle during RUN -> result matches the operands captured at accept.
REQ-038 Reset at RUN cycle 4 -> all outputs at reset values without a clock edge; no out_valid until a new accept completes; then random add/sub vs reference model, 1000 operations, zero mismatches.
